serial_cmp_accum: RTL and testbench

Bit-serial magnitude-compare accumulator that widens the 2-bit comparator slice into an N-slice word comparator. Sits directly downstream of the 2-bit comparator. It consumes one slice result (less/equal/greater) per accepted cycle, most-significant slice first, and produces a registered word-level less/equal/greater with a one-cycle done pulse. The first non-equal slice decides the result; later slices are counted but ignored.

---
 rtl/serial_cmp_accum.sv | 147 ++++++++++++++
 tb/tb_serial_cmp_accum.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_accum.sv
// Bit-serial word comparator: folds NUM_SLICES 2-bit slice results (MS slice first) into a
// registered word-level less/equal/greater. Optional malformed-slice check: SLICE_ONEHOT_CHECK_EN.
module serial_cmp_accum #(
  parameter int NUM_SLICES = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             slice_valid,
  input  logic             slice_less,
  input  logic             slice_equal,
  input  logic             slice_greater,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic [CNT_W-1:0] slice_cnt,
  output logic             slice_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             greater_q, greater_d;
  logic             start_ok;
  logic             accept;

  assign start_ok = start && (state_q != ACCUM);
  assign accept   = (state_q == ACCUM) && slice_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dec_q     <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
      less_q    <= less_d;
      equal_q   <= equal_d;
      greater_q <= greater_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    less_d    = less_q;
    equal_d   = equal_q;
    greater_d = greater_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = ACCUM;
          cnt_d   = '0;
          dec_d   = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          // First non-equal slice decides; greater wins over less on a malformed slice.
          if (!dec_q) begin
            if (slice_greater) begin
              gt_d  = 1'b1;
              dec_d = 1'b1;
            end else if (slice_less) begin
              lt_d  = 1'b1;
              dec_d = 1'b1;
            end
          end
          if (cnt_q == LAST_CNT) begin
            state_d   = DONE;
            less_d    = lt_d;
            greater_d = gt_d;
            equal_d   = !(lt_d || gt_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == ACCUM);
  assign done      = (state_q == DONE);
  assign less      = less_q;
  assign equal     = equal_q;
  assign greater   = greater_q;
  assign slice_cnt = cnt_q;

`ifdef SLICE_ONEHOT_CHECK_EN
  logic err_q, err_d;
  logic onehot;

  always_comb begin
    case ({slice_less, slice_equal, slice_greater})
      3'b100, 3'b010, 3'b001: onehot = 1'b1;
      default:                onehot = 1'b0;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (start_ok)
      err_d = 1'b0;
    else if (accept && !onehot)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign slice_err = err_q;
`else
  logic unused_equal;
  assign unused_equal = slice_equal;
  assign slice_err    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cmp_accum.sv
// Directed self-checking bench for serial_cmp_accum (NUM_SLICES=4); expectations are hand-derived.
module tb_serial_cmp_accum;

  logic       clk;
  logic       rst;
  logic       start;
  logic       slice_valid;
  logic       slice_less;
  logic       slice_equal;
  logic       slice_greater;
  logic       busy;
  logic       done;
  logic       less;
  logic       equal;
  logic       greater;
  logic [2:0] slice_cnt;
  logic       slice_err;

  int checks = 0;
  int errors = 0;

  serial_cmp_accum #(.NUM_SLICES(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .slice_valid  (slice_valid),
    .slice_less   (slice_less),
    .slice_equal  (slice_equal),
    .slice_greater(slice_greater),
    .busy         (busy),
    .done         (done),
    .less         (less),
    .equal        (equal),
    .greater      (greater),
    .slice_cnt    (slice_cnt),
    .slice_err    (slice_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One accepted slice; flags given as less, equal, greater.
  task automatic slice(input logic l, input logic e, input logic g);
    slice_valid   = 1'b1;
    slice_less    = l;
    slice_equal   = e;
    slice_greater = g;
    step();
    slice_valid   = 1'b0;
    slice_less    = 1'b0;
    slice_equal   = 1'b0;
    slice_greater = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic l, input logic e, input logic g);
    chk({tag, "_less"}, {31'd0, less}, {31'd0, l});
    chk({tag, "_equal"}, {31'd0, equal}, {31'd0, e});
    chk({tag, "_greater"}, {31'd0, greater}, {31'd0, g});
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    slice_valid = 1'b0;
    slice_less = 1'b0;
    slice_equal = 1'b0;
    slice_greater = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", {29'd0, slice_cnt}, 32'd0);
    chk("rst_err", {31'd0, slice_err}, 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Reset mid-word: two slices in, then async reset
    do_start();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    slice(1'b0, 1'b1, 1'b0);
    slice(1'b0, 1'b1, 1'b0);
    chk("mid_cnt_pre", {29'd0, slice_cnt}, 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_cnt", {29'd0, slice_cnt}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk_flags("mid", 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("mid_done_later", {31'd0, done}, 32'd0);
    rst = 1'b0;
    step();

    // 8'hB4 vs 8'hB2: E E G L -> greater, done 5 edges after start
    do_start();
    chk("b4_busy", {31'd0, busy}, 32'd1);
    chk("b4_done_e1", {31'd0, done}, 32'd0);
    slice(1'b0, 1'b1, 1'b0);
    slice(1'b0, 1'b1, 1'b0);
    slice(1'b0, 1'b0, 1'b1);
    chk("b4_done_e4", {31'd0, done}, 32'd0);
    chk_flags("b4_hold", 1'b0, 1'b0, 1'b0);
    slice(1'b1, 1'b0, 1'b0);
    chk("b4_done_e5", {31'd0, done}, 32'd1);
    chk("b4_busy_done", {31'd0, busy}, 32'd0);
    chk("b4_cnt", {29'd0, slice_cnt}, 32'd4);
    chk_flags("b4", 1'b0, 1'b0, 1'b1);
    step();
    chk("b4_done_pulse", {31'd0, done}, 32'd0);
    chk("b4_cnt_idle", {29'd0, slice_cnt}, 32'd4);
    chk_flags("b4_held", 1'b0, 1'b0, 1'b1);

    // Equal word
    do_start();
    chk("eq_cnt_clear", {29'd0, slice_cnt}, 32'd0);
    repeat (4) slice(1'b0, 1'b1, 1'b0);
    chk("eq_done", {31'd0, done}, 32'd1);
    chk_flags("eq", 1'b0, 1'b1, 1'b0);
    step();

    // Stall of 3 cycles between slices 2 and 3: L G - - - G G -> less at edge 8
    do_start();
    slice(1'b1, 1'b0, 1'b0);
    slice(1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    chk("stall_cnt", {29'd0, slice_cnt}, 32'd2);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    slice(1'b0, 1'b0, 1'b1);
    chk("stall_done_e7", {31'd0, done}, 32'd0);
    slice(1'b0, 1'b0, 1'b1);
    chk("stall_done_e8", {31'd0, done}, 32'd1);
    chk_flags("stall", 1'b1, 1'b0, 1'b0);
    step();

    // Back-to-back: mid-ACCUM start ignored, start in DONE restarts at once
    do_start();
    slice(1'b0, 1'b1, 1'b0);
    start = 1'b1;
    slice(1'b0, 1'b0, 1'b1);
    start = 1'b0;
    chk("b2b_cnt_nostart", {29'd0, slice_cnt}, 32'd2);
    slice(1'b0, 1'b1, 1'b0);
    slice(1'b1, 1'b0, 1'b0);
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk_flags("b2b_w1", 1'b0, 1'b0, 1'b1);
    do_start();
    chk("b2b_busy2", {31'd0, busy}, 32'd1);
    chk("b2b_done_off", {31'd0, done}, 32'd0);
    chk("b2b_cnt2", {29'd0, slice_cnt}, 32'd0);
    slice(1'b1, 1'b0, 1'b0);
    slice(1'b0, 1'b0, 1'b1);
    chk_flags("b2b_w1_held", 1'b0, 1'b0, 1'b1);
    slice(1'b0, 1'b1, 1'b0);
    slice(1'b0, 1'b1, 1'b0);
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk_flags("b2b_w2", 1'b1, 1'b0, 1'b0);
    step();

    // Malformed slice 1 (less and greater both set): priority gives greater
    do_start();
    slice(1'b1, 1'b0, 1'b1);
`ifdef SLICE_ONEHOT_CHECK_EN
    chk("oh_err_set", {31'd0, slice_err}, 32'd1);
`else
    chk("oh_err_set", {31'd0, slice_err}, 32'd0);
`endif
    repeat (3) slice(1'b0, 1'b1, 1'b0);
    chk("oh_done", {31'd0, done}, 32'd1);
    chk_flags("oh", 1'b0, 1'b0, 1'b1);
    step();
`ifdef SLICE_ONEHOT_CHECK_EN
    chk("oh_err_sticky", {31'd0, slice_err}, 32'd1);
`else
    chk("oh_err_sticky", {31'd0, slice_err}, 32'd0);
`endif
    do_start();
    chk("oh_err_clear", {31'd0, slice_err}, 32'd0);
    repeat (4) slice(1'b0, 1'b1, 1'b0);
    chk_flags("oh_after", 1'b0, 1'b1, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
